// File: rtl/nes_mem_arbiter_if.sv
// Bus bundle between the loader/CPU/PPU requesters, the arbiter and the SDRAM request port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface nes_mem_arbiter_if #(
  parameter int ADDR_W = 22
);
  logic              download;
  logic              ldr_req;
  logic [ADDR_W-1:0] ldr_addr;
  logic [7:0]        ldr_data;
  logic              ldr_ack;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;
  logic              ppu_req;
  logic [ADDR_W-1:0] ppu_addr;
  logic              ppu_ack;
  logic [7:0]        ppu_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic [1:0]        grant;
  logic              timeout_err;

  modport slave (
    input  download, ldr_req, ldr_addr, ldr_data,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ppu_req, ppu_addr, mem_ack, mem_rdata,
    output ldr_ack, cpu_ack, cpu_rdata, ppu_ack, ppu_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, grant, timeout_err
  );

  modport master (
    output download, ldr_req, ldr_addr, ldr_data,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ppu_req, ppu_addr, mem_ack, mem_rdata,
    input  ldr_ack, cpu_ack, cpu_rdata, ppu_ack, ppu_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, grant, timeout_err
  );
endinterface

// File: rtl/nes_mem_arbiter.sv
// Shares the SDRAM request port between ROM loader, CPU and PPU: loader first,
// CPU/PPU round-robin, CPU/PPU masked during download, watchdog on every access.
module nes_mem_arbiter #(
  parameter int ADDR_W  = 22,
  parameter int TIMEOUT = 255
) (
  input logic              CLK_50M,
  input logic              reset,
  nes_mem_arbiter_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_LDR  = 2'd1;
  localparam logic [1:0] G_CPU  = 2'd2;
  localparam logic [1:0] G_PPU  = 2'd3;

  localparam logic [7:0] WD_LOAD = 8'(TIMEOUT);

  logic [1:0]        state_reg;
  logic [7:0]        wd_reg;
  logic              rr_reg;     // 1 = PPU wins the next CPU/PPU tie
  logic [1:0]        pick;
  logic [ADDR_W-1:0] pick_addr;
  logic              pick_we;
  logic [7:0]        pick_wdata;
  logic [7:0]        rsp_data;

  always_comb begin
    pick = G_NONE;
    if (bus.ldr_req) begin
      pick = G_LDR;
    end else if (!bus.download) begin
      if (bus.cpu_req && (!bus.ppu_req || !rr_reg)) begin
        pick = G_CPU;
      end else if (bus.ppu_req) begin
        pick = G_PPU;
      end
    end
  end

  always_comb begin
    pick_addr  = '0;
    pick_we    = 1'b0;
    pick_wdata = 8'h00;
    case (pick)
      G_LDR: begin
        pick_addr  = bus.ldr_addr;
        pick_we    = 1'b1;
        pick_wdata = bus.ldr_data;
      end
      G_CPU: begin
        pick_addr  = bus.cpu_addr;
        pick_we    = bus.cpu_we;
        pick_wdata = bus.cpu_wdata;
      end
      G_PPU: pick_addr = bus.ppu_addr;
      default: ;
    endcase
  end

  // An aborted read returns all ones so the requester never sees stale data.
  assign rsp_data = bus.mem_ack ? bus.mem_rdata : 8'hFF;

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      wd_reg          <= 8'h00;
      rr_reg          <= 1'b0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= 8'h00;
      bus.grant       <= G_NONE;
      bus.ldr_ack     <= 1'b0;
      bus.cpu_ack     <= 1'b0;
      bus.ppu_ack     <= 1'b0;
      bus.cpu_rdata   <= 8'h00;
      bus.ppu_rdata   <= 8'h00;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.ldr_ack <= 1'b0;
      bus.cpu_ack <= 1'b0;
      bus.ppu_ack <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pick != G_NONE) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= pick_we;
            bus.mem_addr  <= pick_addr;
            bus.mem_wdata <= pick_wdata;
            bus.grant     <= pick;
            wd_reg        <= WD_LOAD;
            state_reg     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.mem_ack || wd_reg == 8'd1) begin
            bus.mem_req <= 1'b0;
            if (!bus.mem_ack) begin
              bus.timeout_err <= 1'b1;
            end
            if (bus.grant == G_CPU && !bus.mem_we) begin
              bus.cpu_rdata <= rsp_data;
            end
            if (bus.grant == G_PPU) begin
              bus.ppu_rdata <= rsp_data;
            end
            bus.ldr_ack <= (bus.grant == G_LDR);
            bus.cpu_ack <= (bus.grant == G_CPU);
            bus.ppu_ack <= (bus.grant == G_PPU);
            state_reg   <= ST_DONE;
          end else begin
            wd_reg <= wd_reg - 8'd1;
          end
        end
        ST_DONE: begin
          if (bus.grant == G_CPU) begin
            rr_reg <= 1'b1;
          end else if (bus.grant == G_PPU) begin
            rr_reg <= 1'b0;
          end
          bus.grant <= G_NONE;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule
